// File: rtl/core_pkg.sv
// Shared types and constants for the multicycle 9-bit-ISA core.
package core_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_XOR  = 3'b011,
        OP_LD   = 3'b100,
        OP_ST   = 3'b101,
        OP_JNZ  = 3'b110,
        OP_HALT = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_DONE
    } state_e;

    localparam int INSTR_W   = 9;
    localparam int OP_MSB    = 8;
    localparam int OP_LSB    = 6;
    localparam int RD_MSB    = 5;
    localparam int RD_LSB    = 3;
    localparam int RS_MSB    = 2;
    localparam int RS_LSB    = 0;
    localparam int LUT_AW    = 6;
    localparam int LUT_DEPTH = 64;

endpackage

// File: rtl/core_jump_lut.sv
// Runtime-loadable JNZ target table: synchronous write, asynchronous read.
module core_jump_lut
    import core_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [LUT_AW-1:0] waddr,
    input  logic [PC_W-1:0]   wdata,
    input  logic [LUT_AW-1:0] raddr,
    output logic [PC_W-1:0]   rdata
);

    logic [PC_W-1:0] entries [LUT_DEPTH];

    // NOTE: the table is reset so a JNZ taken before any load lands on PC 0 deterministically.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) entries[i] <= '0;
        end else if (we) begin
            entries[waddr] <= wdata;
        end
    end

    // A write in the same cycle as a read returns the old entry.
    assign rdata = entries[raddr];

endmodule

// File: rtl/multicycle_core.sv
// Multicycle 9-bit-ISA core: FETCH/EXEC/MEM FSM with req/ack instruction and data ports.
module multicycle_core
    import core_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PC_W    = 10,
    parameter int NREGS   = 8,
    parameter int DONE_PC = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_waddr,
    input  logic [PC_W-1:0]   lut_wdata,
    output logic              busy,
    output logic              done,
    output logic [PC_W-1:0]   pc
);

    state_e              state, state_nx;
    logic [INSTR_W-1:0]  ir;
    logic [DATA_W-1:0]   regs [NREGS];
    opcode_e             op;
    logic [2:0]          rd, rs;
    logic [DATA_W-1:0]   rd_val, rs_val, alu_y;
    logic [PC_W-1:0]     pc_inc, lut_rdata;
    logic                at_done_pc;

    assign op         = opcode_e'(ir[OP_MSB:OP_LSB]);
    assign rd         = ir[RD_MSB:RD_LSB];
    assign rs         = ir[RS_MSB:RS_LSB];
    assign rd_val     = regs[rd];
    assign rs_val     = regs[rs];
    assign pc_inc     = pc + PC_W'(1);
    assign at_done_pc = (pc == PC_W'(DONE_PC));

    assign imem_addr  = pc;
    assign dmem_addr  = (op == OP_ST) ? rd_val : rs_val;
    assign dmem_wdata = rs_val;

    core_jump_lut #(.PC_W(PC_W)) u_lut (
        .clk   (clk),
        .reset (reset),
        .we    (lut_we),
        .waddr (lut_waddr),
        .wdata (lut_wdata),
        .raddr (ir[LUT_AW-1:0]),
        .rdata (lut_rdata)
    );

    always_comb begin
        alu_y = '0;
        case (op)
            OP_ADD:  alu_y = rd_val + rs_val;
            OP_SUB:  alu_y = rd_val - rs_val;
            OP_AND:  alu_y = rd_val & rs_val;
            OP_XOR:  alu_y = rd_val ^ rs_val;
            default: alu_y = '0;
        endcase
    end

    // NOTE: every output is given a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_nx = state;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: if (start) state_nx = S_FETCH;
            S_FETCH: begin
                busy = 1'b1;
                if (at_done_pc) begin
                    state_nx = S_DONE;
                end else begin
                    imem_req = 1'b1;
                    if (imem_ack) state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                busy = 1'b1;
                case (op)
                    OP_LD, OP_ST: state_nx = S_MEM;
                    OP_HALT:      state_nx = S_DONE;
                    default:      state_nx = S_FETCH;
                endcase
            end
            S_MEM: begin
                busy     = 1'b1;
                dmem_req = 1'b1;
                dmem_we  = (op == OP_ST);
                if (dmem_ack) state_nx = S_FETCH;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_nx = S_FETCH;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // NOTE: state-holding blocks use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0;
            ir <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start) pc <= '0;
                S_FETCH: if (imem_req && imem_ack) ir <= imem_rdata;
                S_EXEC: begin
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
                            regs[rd] <= alu_y;
                            pc       <= pc_inc;
                        end
                        OP_JNZ:  pc <= (regs[0] != '0) ? lut_rdata : pc_inc;
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (op == OP_LD) regs[rd] <= dmem_rdata;
                        pc <= pc_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_core.sv
// Self-checking bench for multicycle_core: wait-state memory models and a store scoreboard.
module tb_multicycle_core;

    localparam int DATA_W  = 8;
    localparam int PC_W    = 10;
    localparam int DONE_PC = 128;
    localparam int BOUND   = 4000;

    localparam logic [2:0] O_ADD = 3'd0, O_SUB = 3'd1, O_AND = 3'd2, O_XOR = 3'd3;
    localparam logic [2:0] O_LD  = 3'd4, O_ST  = 3'd5, O_JNZ = 3'd6, O_HALT = 3'd7;

    logic              clk, reset, start;
    logic              imem_req, imem_ack;
    logic [PC_W-1:0]   imem_addr;
    logic [8:0]        imem_rdata;
    logic              dmem_req, dmem_we, dmem_ack;
    logic [DATA_W-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic              lut_we;
    logic [5:0]        lut_waddr;
    logic [PC_W-1:0]   lut_wdata;
    logic              busy, done;
    logic [PC_W-1:0]   pc;

    multicycle_core #(.DATA_W(DATA_W), .PC_W(PC_W), .NREGS(8), .DONE_PC(DONE_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .lut_we     (lut_we),
        .lut_waddr  (lut_waddr),
        .lut_wdata  (lut_wdata),
        .busy       (busy),
        .done       (done),
        .pc         (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models with programmable wait states
    logic [8:0]        imem [1024];
    logic [DATA_W-1:0] dmem [256];
    int iwait = 0, dwait = 0, icnt = 0, dcnt = 0;

    assign imem_ack   = imem_req && (icnt == iwait);
    assign imem_rdata = imem[imem_addr];
    assign dmem_ack   = dmem_req && (dcnt == dwait);
    assign dmem_rdata = dmem[dmem_addr];

    // Bus monitor: fetch count, request stability, store capture
    int fetch_n = 0, st_n = 0, stab_err = 0, done_pc_fetch = 0;
    logic              ipend = 1'b0, dpend = 1'b0, dwe_q = 1'b0;
    logic [PC_W-1:0]   iaddr_q = '0;
    logic [DATA_W-1:0] daddr_q = '0, dwdata_q = '0;
    logic [DATA_W-1:0] st_addr [512];
    logic [DATA_W-1:0] st_data [512];
    logic ibad, dbad;

    assign ibad = imem_req && ipend && (imem_addr != iaddr_q);
    assign dbad = dmem_req && dpend && ((dmem_addr != daddr_q) || (dmem_we != dwe_q) ||
                                        (dmem_we && (dmem_wdata != dwdata_q)));

    always @(posedge clk) begin
        icnt     <= (imem_req && !imem_ack) ? icnt + 1 : 0;
        dcnt     <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
        stab_err <= stab_err + int'(ibad) + int'(dbad);
        ipend    <= imem_req && !imem_ack;
        dpend    <= dmem_req && !dmem_ack;
        iaddr_q  <= imem_addr;
        daddr_q  <= dmem_addr;
        dwe_q    <= dmem_we;
        dwdata_q <= dmem_wdata;
        if (imem_req && imem_ack) fetch_n <= fetch_n + 1;
        if (imem_req && imem_addr == PC_W'(DONE_PC)) done_pc_fetch <= done_pc_fetch + 1;
        if (dmem_req && dmem_ack && dmem_we) begin
            st_addr[st_n % 512] <= dmem_addr;
            st_data[st_n % 512] <= dmem_wdata;
            st_n <= st_n + 1;
        end
    end

    // Scoreboard of expected stores
    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } store_t;
    store_t exp_q[$];
    int rd_idx = 0;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
    } alu_vec_t;
    alu_vec_t vecs[6];

    int n_cmp = 0, n_bad = 0;
    logic hazard_en = 1'b0, poke_start = 1'b0;
    logic [PC_W-1:0] first_pc, first_addr;
    logic first_req, first_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] ins(input logic [2:0] op, input int rd, input int rs);
        return {op, rd[2:0], rs[2:0]};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) imem[i] = '0;
        for (int i = 0; i < 256; i++)  dmem[i] = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0; start = 1'b0; lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic lut_write(input int idx, input int tgt);
        lut_we = 1'b1; lut_waddr = idx[5:0]; lut_wdata = tgt[PC_W-1:0];
        @(negedge clk);
        lut_we = 1'b0;
    endtask

    // Pulse start, then run to done counting busy cycles; optional hazard/start-poke stimulus.
    task automatic run_prog(output int cyc);
        int n, jn, hz;
        n = 0; jn = 0; hz = 0; cyc = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        first_pc = pc; first_addr = imem_addr; first_req = imem_req; first_done = done;
        while (!done && n < BOUND) begin
            if (busy) cyc++;
            if (hz == 1) begin
                lut_we = 1'b1; lut_waddr = 6'd5; lut_wdata = 10'd5; hz = 2;
            end else if (hz == 2) begin
                lut_we = 1'b0;
                check("jnz_hazard_old_target", pc, 2);
                hz = 3;
            end
            if (hazard_en && imem_req && imem_ack && imem_addr == 10'd4) begin
                jn++;
                if (jn == 2) hz = 1;
            end
            start = (poke_start && n == 5);
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        check("done_reached", done, 1);
        check("busy_low_at_done", busy, 0);
    endtask

    task automatic drain(input string name);
        int n;
        store_t e;
        n = st_n - rd_idx;
        check({name, "_store_count"}, n, exp_q.size());
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({name, "_store_addr"}, st_addr[rd_idx % 512], e.addr);
                check({name, "_store_data"}, st_data[rd_idx % 512], e.data);
            end
            rd_idx++;
        end
        exp_q.delete();
    endtask

    task automatic load_alu(input alu_vec_t v);
        clear_mem();
        imem[0] = ins(O_LD, 1, 0);
        imem[1] = ins(O_LD, 2, 1);
        imem[2] = ins(O_ADD, 1, 1);
        imem[3] = ins(O_LD, 3, 1);
        imem[4] = ins(v.op, 2, 3);
        imem[5] = ins(O_ST, 1, 2);
        imem[6] = {O_HALT, 6'd0};
        dmem[0] = 8'd1; dmem[1] = v.a; dmem[2] = v.b;
    endtask

    initial begin
        int cyc, f0, s0, d0, n;
        string nm;

        vecs[0] = '{O_SUB, 8'd5,   8'd3,   8'd2};
        vecs[1] = '{O_ADD, 8'd200, 8'd100, 8'd44};
        vecs[2] = '{O_SUB, 8'd3,   8'd5,   8'd254};
        vecs[3] = '{O_AND, 8'hF0,  8'h3C,  8'h30};
        vecs[4] = '{O_XOR, 8'hFF,  8'h0F,  8'hF0};
        vecs[5] = '{O_ADD, 8'hFF,  8'h01,  8'h00};

        // Reset state
        clear_mem();
        reset = 1'b0; start = 1'b0; lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_imem_req", imem_req, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_dmem_we", dmem_we, 0);
        check("rst_pc", pc, 0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_imem_req", imem_req, 0);

        // ALU table, zero-wait and wait-state memories
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 6; i++) begin
                iwait = (w != 0) ? 3 : 0;
                dwait = (w != 0) ? 2 : 0;
                load_alu(vecs[i]);
                do_reset();
                exp_q.push_back('{addr: 8'd2, data: vecs[i].res});
                f0 = fetch_n; s0 = stab_err;
                run_prog(cyc);
                nm = $sformatf("alu%0d_w%0d", i, w);
                check({nm, "_pc"}, pc, 6);
                check({nm, "_cycles"}, cyc, (w != 0) ? 47 : 18);
                check({nm, "_fetches"}, fetch_n - f0, 7);
                check({nm, "_stable"}, stab_err - s0, 0);
                drain(nm);
            end
        end
        iwait = 0; dwait = 0;

        // JNZ loop, plain and with same-cycle LUT write
        for (int hz = 0; hz < 2; hz++) begin
            clear_mem();
            imem[0] = ins(O_LD, 1, 0);
            imem[1] = ins(O_LD, 0, 1);
            imem[2] = ins(O_SUB, 0, 1);
            imem[3] = ins(O_ADD, 2, 1);
            imem[4] = {O_JNZ, 6'd5};
            imem[5] = ins(O_ST, 1, 2);
            imem[6] = {O_HALT, 6'd0};
            dmem[0] = 8'd1; dmem[1] = 8'd3;
            do_reset();
            lut_write(5, 2);
            exp_q.push_back('{addr: 8'd1, data: 8'd3});
            hazard_en = (hz != 0);
            f0 = fetch_n;
            run_prog(cyc);
            hazard_en = 1'b0;
            nm = $sformatf("jnz_hz%0d", hz);
            check({nm, "_pc"}, pc, 6);
            check({nm, "_cycles"}, cyc, 29);
            check({nm, "_fetches"}, fetch_n - f0, 13);
            drain(nm);
        end

        // Store driving address from rd and data from rs
        clear_mem();
        imem[0] = ins(O_LD, 1, 0);
        imem[1] = ins(O_LD, 3, 1);
        imem[2] = ins(O_ADD, 1, 1);
        imem[3] = ins(O_LD, 4, 1);
        imem[4] = ins(O_ST, 3, 4);
        imem[5] = {O_HALT, 6'd0};
        dmem[0] = 8'd1; dmem[1] = 8'hFF; dmem[2] = 8'hA5;
        do_reset();
        exp_q.push_back('{addr: 8'hFF, data: 8'hA5});
        run_prog(cyc);
        check("st_pc", pc, 5);
        check("st_cycles", cyc, 16);
        drain("st");

        // DONE_PC boundary with no HALT, then restart
        clear_mem();
        do_reset();
        f0 = fetch_n; d0 = done_pc_fetch;
        run_prog(cyc);
        check("donepc_pc", pc, DONE_PC);
        check("donepc_cycles", cyc, 257);
        check("donepc_fetches", fetch_n - f0, 128);
        check("donepc_no_fetch", done_pc_fetch - d0, 0);
        drain("donepc");
        run_prog(cyc);
        check("restart_pc", first_pc, 0);
        check("restart_req", first_req, 1);
        check("restart_addr", first_addr, 0);
        check("restart_done_cleared", first_done, 0);
        check("restart_cycles", cyc, 257);
        drain("restart");

        // Reset while a load is pending
        load_alu(vecs[0]);
        dwait = 5;
        do_reset();
        f0 = fetch_n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while ((fetch_n - f0 < 4 || !dmem_req) && n < BOUND) begin
            n++;
            @(negedge clk);
        end
        check("abort_dmem_req_seen", dmem_req, 1);
        reset = 1'b0;
        #1;
        check("abort_dmem_req", dmem_req, 0);
        check("abort_dmem_we", dmem_we, 0);
        check("abort_imem_req", imem_req, 0);
        check("abort_busy", busy, 0);
        check("abort_pc", pc, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        dwait = 0;
        check("post_abort_busy", busy, 0);

        // Registers read back as zero; a start pulse mid-run is ignored
        clear_mem();
        for (int k = 1; k < 8; k++) begin
            imem[k-1] = ins(O_ST, 0, k);
            exp_q.push_back('{addr: 8'd0, data: 8'd0});
        end
        imem[7] = {O_HALT, 6'd0};
        poke_start = 1'b1;
        f0 = fetch_n;
        run_prog(cyc);
        poke_start = 1'b0;
        check("dump_pc", pc, 7);
        check("dump_cycles", cyc, 23);
        check("dump_fetches", fetch_n - f0, 8);
        drain("dump");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
